kmeans_centroid_update_k2_d4: RTL and testbench
===============================================

KMEANS_CENTROID_UPDATE_K2_D4 -- requirements
Module: kmeans_centroid_update_k2_d4

Interface
REQ-001 SHALL have parameter input_data_width, default 16, meaning the unsigned sample and centroid component width.
REQ-002 SHALL have parameter count_width, default 16, meaning the per-centroid sample counter width; the accumulator width is SUM_W = input_data_width + count_width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports input_data0..input_data3, input, input_data_width each: the assigned sample, one port per dimension.
REQ-006 SHALL have port selected_centroid, input, 1 bit: the centroid index assigned to the sample.
REQ-007 SHALL have port in_valid, input, 1 bit: the sample on the input ports is present.
REQ-008 SHALL have port in_ready, output, 1 bit: samples are accepted this cycle.
REQ-009 SHALL have port epoch_done, input, 1 bit: marks the end of an epoch and is sampled only while in_ready=1.
REQ-010 SHALL have ports centroid0_d0..d3 and centroid1_d0..d3, output, input_data_width each: the registered current centroids.
REQ-011 SHALL have port centroid_valid, output, 1 bit: one-cycle pulse when new centroids appear.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when any counter would wrap during the current epoch.

Function
REQ-013 SHALL implement FSM states ACCUM, DIVIDE and PUBLISH; in_ready=1 only in ACCUM.
REQ-014 In ACCUM, when in_valid=1 at an edge, SHALL add each input_dataN into sum_k<sel>_dN (SUM_W bits) and increment count_k<sel>.
REQ-015 When in_valid and epoch_done are both 1 at the same edge, SHALL accumulate that sample and then go to DIVIDE.
REQ-016 epoch_done with in_valid=0 SHALL go to DIVIDE with no accumulation.
REQ-017 DIVIDE SHALL compute 8 truncating unsigned quotients sum/count sequentially, in order k0d0..k0d3, k1d0..k1d3.
REQ-018 Each quotient SHALL take exactly SUM_W+1 cycles.
REQ-019 The quotient SHALL be the low input_data_width bits of the result; a quotient never exceeds the maximum input value.
REQ-020 If count_k==0 (empty cluster), SHALL keep that centroid's previous value for all dimensions; the division slot still consumes its SUM_W+1 cycles so latency stays fixed.
REQ-021 SHALL hold quotients in shadow registers and update all 8 centroid outputs in the same cycle, entering PUBLISH.
REQ-022 PUBLISH SHALL last exactly 1 cycle: centroid_valid=1, all sums and counts cleared, overflow cleared, then return to ACCUM.
REQ-023 Latency SHALL be: centroid_valid asserted exactly 8*(SUM_W+1)+2 cycles after the epoch_done acceptance edge (266 cycles with the defaults).
REQ-024 If count_k is at all-ones and another sample for k arrives, SHALL set overflow, leave that count and sum unchanged, and drop the sample.
REQ-025 in_valid and epoch_done asserted outside ACCUM SHALL be ignored, with no state change.

Reset
REQ-026 On rst_n=0, asynchronously and regardless of state, SHALL clear all centroid outputs, sums, counts, shadow registers, centroid_valid and overflow, and enter ACCUM.
REQ-027 A reset mid-DIVIDE SHALL abort the division, with no centroid_valid pulse.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the SUM_W derivation and the divider cycle-count constant.
REQ-030 SHALL contain one sub-module, kmeans_seq_divider: a restoring divider with start/done handshake, SUM_W-bit dividend and count_width-bit divisor, done exactly SUM_W+1 cycles after start.

Verification
REQ-031 Samples k0:(10,20,30,40), k0:(20,40,60,80), k1:(4,4,4,4), then epoch_done -> centroid0=(15,30,45,60), centroid1=(4,4,4,4), centroid_valid exactly 266 cycles later.
REQ-032 Samples k0:(1,2,3,4), k0:(2,2,2,2), the second with epoch_done in the same cycle -> centroid0=(1,2,2,3) (truncated), centroid1=0 (empty cluster).
REQ-033 Epoch1 gives centroid1=(7,7,7,7); epoch2 has only k0 samples -> centroid1 stays (7,7,7,7) and in_ready=0 for 265 cycles.
REQ-034 With count_width=2: four k0 samples of (8,8,8,8) -> overflow=1, centroid0=(8,8,8,8); overflow=0 after PUBLISH.
REQ-035 rst_n pulsed low 100 cycles into DIVIDE -> no centroid_valid, all outputs 0, in_ready=1 next cycle.
REQ-036 in_valid=1 for 266 cycles during DIVIDE -> sums unchanged; the next epoch's results exclude those samples.

Source files
------------

// File: rtl/kmeans_centroid_update_k2_d4_pkg.sv
// kmeans_centroid_update_k2_d4_pkg
// Shared definitions for the two-centroid, four-dimension k-means centroid
// updater and its sequential divider.
//   state_t      : top-level FSM states (ACCUM, DIVIDE, PUBLISH)
//   sumWidth()   : accumulator width derived from sample and counter widths
//   divCycles()  : number of cycles one division occupies
//   NUM_*        : fixed geometry of the block (2 centroids x 4 dimensions)
package kmeans_centroid_update_k2_d4_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIVIDE  = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_COUNT_W = 16;
  localparam int NUM_CENTROIDS   = 2;
  localparam int NUM_DIMS        = 4;
  localparam int NUM_SLOTS       = NUM_CENTROIDS * NUM_DIMS;
  localparam int SLOT_W          = 3;

  // A sum of up to (2^countW - 1) samples of dataW bits never needs more than
  // dataW + countW bits, so the accumulators cannot wrap.
  function automatic int sumWidth(input int dataW, input int countW);
    return dataW + countW;
  endfunction

  // One quotient bit per dividend bit, plus the cycle that loads the operands.
  function automatic int divCycles(input int sumW);
    return sumW + 1;
  endfunction

endpackage

// File: rtl/kmeans_seq_divider.sv
// kmeans_seq_divider
// Restoring unsigned divider producing one quotient bit per cycle.
//   clk, rst_n  : clock and asynchronous active-low reset
//   i_start     : loads the operands; may be asserted in the same cycle as o_done
//   i_dividend  : SUM_W-bit dividend
//   i_divisor   : COUNT_W-bit divisor (a zero divisor gives a harmless, unused result)
//   o_done      : one-cycle pulse, high SUM_W+1 cycles after the start cycle
//   o_quotient  : low QUO_W bits of the quotient, valid while o_done is high
module kmeans_seq_divider
  import kmeans_centroid_update_k2_d4_pkg::*;
#(
  parameter int SUM_W   = 32,
  parameter int COUNT_W = 16,
  parameter int QUO_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [SUM_W-1:0]   i_dividend,
  input  logic [COUNT_W-1:0] i_divisor,
  output logic               o_done,
  output logic [QUO_W-1:0]   o_quotient
);

  localparam int CNT_W = $clog2(divCycles(SUM_W));

  logic [COUNT_W-1:0] r_rem;
  logic [SUM_W-1:0]   r_quo;
  logic [COUNT_W-1:0] r_divisor;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [COUNT_W:0]   w_remShift;
  logic [COUNT_W:0]   w_diff;

  // The remainder is always below the divisor, so the shifted remainder fits
  // in COUNT_W+1 bits and the top bit of the difference is a clean borrow.
  assign w_remShift = {r_rem, r_quo[SUM_W-1]};
  assign w_diff     = w_remShift - {1'b0, r_divisor};

  // Start loads the operands; each busy cycle then shifts one dividend bit into
  // the remainder and one quotient bit into the freed low end of r_quo.  The
  // last iteration raises done so the caller can chain the next division on
  // the very cycle it collects this quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_start) begin
      r_rem     <= '0;
      r_quo     <= i_dividend;
      r_divisor <= i_divisor;
      r_cnt     <= CNT_W'(SUM_W);
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else if (r_busy) begin
      if (!w_diff[COUNT_W]) begin
        r_rem <= w_diff[COUNT_W-1:0];
        r_quo <= {r_quo[SUM_W-2:0], 1'b1};
      end else begin
        r_rem <= w_remShift[COUNT_W-1:0];
        r_quo <= {r_quo[SUM_W-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo[QUO_W-1:0];

endmodule

// File: rtl/kmeans_centroid_update_k2_d4.sv
// kmeans_centroid_update_k2_d4
// Accumulates assigned samples per centroid over an epoch, then divides each
// per-dimension sum by the sample count and publishes the new centroids.
//   clk, rst_n                 : clock and asynchronous active-low reset
//   input_data0..3             : sample components
//   selected_centroid          : centroid the sample belongs to
//   in_valid / in_ready        : sample handshake (ready only while accumulating)
//   epoch_done                 : closes the epoch (sampled while in_ready=1)
//   centroid0_d0..centroid1_d3 : registered current centroids
//   centroid_valid             : one-cycle pulse when new centroids appear
//   overflow                   : sticky flag for samples dropped on a full counter
module kmeans_centroid_update_k2_d4
  import kmeans_centroid_update_k2_d4_pkg::*;
#(
  parameter int input_data_width = DEFAULT_DATA_W,
  parameter int count_width      = DEFAULT_COUNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [input_data_width-1:0] input_data0,
  input  logic [input_data_width-1:0] input_data1,
  input  logic [input_data_width-1:0] input_data2,
  input  logic [input_data_width-1:0] input_data3,
  input  logic                        selected_centroid,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        epoch_done,
  output logic [input_data_width-1:0] centroid0_d0,
  output logic [input_data_width-1:0] centroid0_d1,
  output logic [input_data_width-1:0] centroid0_d2,
  output logic [input_data_width-1:0] centroid0_d3,
  output logic [input_data_width-1:0] centroid1_d0,
  output logic [input_data_width-1:0] centroid1_d1,
  output logic [input_data_width-1:0] centroid1_d2,
  output logic [input_data_width-1:0] centroid1_d3,
  output logic                        centroid_valid,
  output logic                        overflow
);

  localparam int SUM_W = sumWidth(input_data_width, count_width);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  // Slot index = {centroid, dimension}, so slots 0..3 belong to centroid 0.
  state_t                      r_state;
  logic [SUM_W-1:0]            r_sum      [NUM_SLOTS];
  logic [count_width-1:0]      r_count    [NUM_CENTROIDS];
  logic [input_data_width-1:0] r_centroid [NUM_SLOTS];
  logic [input_data_width-1:0] r_shadow   [NUM_SLOTS];
  logic [SLOT_W-1:0]           r_slot;
  logic                        r_startPending;
  logic                        r_publishNext;
  logic                        r_centroidValid;
  logic                        r_overflow;

  logic [input_data_width-1:0] w_inData [NUM_DIMS];
  logic [SLOT_W-1:0]           w_startSlot;
  logic                        w_divStart;
  logic                        w_divDone;
  logic [input_data_width-1:0] w_quotient;
  logic [SUM_W-1:0]            w_dividend;
  logic [count_width-1:0]      w_divisor;

  assign w_inData[0] = input_data0;
  assign w_inData[1] = input_data1;
  assign w_inData[2] = input_data2;
  assign w_inData[3] = input_data3;

  // The first division is launched from a flag set when the epoch closes, so
  // it sees sums that already include a sample accepted alongside epoch_done.
  // Every later division is launched on the cycle the previous one reports
  // done, which keeps each slot at exactly one divider period.
  assign w_startSlot = r_startPending ? r_slot : r_slot + SLOT_W'(1);
  assign w_divStart  = (r_state == DIVIDE) &&
                       (r_startPending || (w_divDone && (r_slot != LAST_SLOT)));
  assign w_dividend  = r_sum[w_startSlot];
  assign w_divisor   = r_count[w_startSlot[SLOT_W-1]];

  kmeans_seq_divider #(
    .SUM_W   (SUM_W),
    .COUNT_W (count_width),
    .QUO_W   (input_data_width)
  ) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_divStart),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_done     (w_divDone),
    .o_quotient (w_quotient)
  );

  // Main FSM and datapath.  ACCUM adds samples into the selected centroid's
  // sums, dropping (and flagging) a sample whose counter is already full.
  // DIVIDE walks the eight slots, parking each quotient in a shadow register;
  // an empty cluster parks its old centroid instead so it stays put.  One
  // cycle after the last quotient, all outputs change together and the FSM
  // enters PUBLISH, which clears the epoch state on its way back to ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ACCUM;
      r_slot          <= '0;
      r_startPending  <= 1'b0;
      r_publishNext   <= 1'b0;
      r_centroidValid <= 1'b0;
      r_overflow      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_sum[i]      <= '0;
        r_centroid[i] <= '0;
        r_shadow[i]   <= '0;
      end
      for (int k = 0; k < NUM_CENTROIDS; k++) begin
        r_count[k] <= '0;
      end
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            if (&r_count[selected_centroid]) begin
              r_overflow <= 1'b1;
            end else begin
              r_count[selected_centroid] <= r_count[selected_centroid] + count_width'(1);
              for (int d = 0; d < NUM_DIMS; d++) begin
                r_sum[{selected_centroid, 2'(d)}] <=
                  r_sum[{selected_centroid, 2'(d)}] + SUM_W'(w_inData[d]);
              end
            end
          end
          if (epoch_done) begin
            r_state        <= DIVIDE;
            r_slot         <= '0;
            r_startPending <= 1'b1;
          end
        end
        DIVIDE: begin
          r_startPending <= 1'b0;
          if (w_divDone) begin
            if (r_count[r_slot[SLOT_W-1]] == '0) begin
              r_shadow[r_slot] <= r_centroid[r_slot];
            end else begin
              r_shadow[r_slot] <= w_quotient;
            end
            if (r_slot == LAST_SLOT) begin
              r_publishNext <= 1'b1;
            end else begin
              r_slot <= r_slot + SLOT_W'(1);
            end
          end
          if (r_publishNext) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              r_centroid[i] <= r_shadow[i];
            end
            r_publishNext   <= 1'b0;
            r_centroidValid <= 1'b1;
            r_state         <= PUBLISH;
          end
        end
        PUBLISH: begin
          r_centroidValid <= 1'b0;
          r_overflow      <= 1'b0;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            r_sum[i] <= '0;
          end
          for (int k = 0; k < NUM_CENTROIDS; k++) begin
            r_count[k] <= '0;
          end
          r_state <= ACCUM;
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready       = (r_state == ACCUM);
  assign centroid_valid = r_centroidValid;
  assign overflow       = r_overflow;
  assign centroid0_d0   = r_centroid[0];
  assign centroid0_d1   = r_centroid[1];
  assign centroid0_d2   = r_centroid[2];
  assign centroid0_d3   = r_centroid[3];
  assign centroid1_d0   = r_centroid[4];
  assign centroid1_d1   = r_centroid[5];
  assign centroid1_d2   = r_centroid[6];
  assign centroid1_d3   = r_centroid[7];

endmodule

// File: tb/tb_kmeans_centroid_update_k2_d4.sv
// tb_kmeans_centroid_update_k2_d4
// Self-checking bench for kmeans_centroid_update_k2_d4: a table of epochs with
// known centroids, randomized epochs against an averaging model, and
// hand-written sequences for reset-in-divide and counter overflow.
module tb_kmeans_centroid_update_k2_d4;

  localparam int DW          = 16;
  localparam int LATENCY     = 8 * (DW + 16 + 1) + 2;
  localparam int LATENCY_SML = 8 * (DW + 2 + 1) + 2;

  typedef struct packed {
    logic             sel;
    logic [3:0][15:0] d;
    logic [1:0]       endMode;
    logic [3:0][15:0] exp0;
    logic [3:0][15:0] exp1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic             aSel, aValid, aDone;
  logic [3:0][15:0] aData;
  logic             aReady, aCv, aOvf;
  logic [3:0][15:0] aCen0, aCen1;

  logic             bSel, bValid, bDone;
  logic [3:0][15:0] bData;
  logic             bReady, bCv, bOvf;
  logic [3:0][15:0] bCen0, bCen1;

  int passCount  = 0;
  int checkCount = 0;

  vec_t             tbl [8];
  longint           mSum [2][4];
  int               mCnt [2];
  logic [3:0][15:0] mCen [2];

  always #5 clk = ~clk;

  kmeans_centroid_update_k2_d4 dutA (
    .clk(clk), .rst_n(rst_n),
    .input_data0(aData[0]), .input_data1(aData[1]),
    .input_data2(aData[2]), .input_data3(aData[3]),
    .selected_centroid(aSel), .in_valid(aValid), .in_ready(aReady),
    .epoch_done(aDone),
    .centroid0_d0(aCen0[0]), .centroid0_d1(aCen0[1]),
    .centroid0_d2(aCen0[2]), .centroid0_d3(aCen0[3]),
    .centroid1_d0(aCen1[0]), .centroid1_d1(aCen1[1]),
    .centroid1_d2(aCen1[2]), .centroid1_d3(aCen1[3]),
    .centroid_valid(aCv), .overflow(aOvf)
  );

  kmeans_centroid_update_k2_d4 #(.input_data_width(16), .count_width(2)) dutB (
    .clk(clk), .rst_n(rst_n),
    .input_data0(bData[0]), .input_data1(bData[1]),
    .input_data2(bData[2]), .input_data3(bData[3]),
    .selected_centroid(bSel), .in_valid(bValid), .in_ready(bReady),
    .epoch_done(bDone),
    .centroid0_d0(bCen0[0]), .centroid0_d1(bCen0[1]),
    .centroid0_d2(bCen0[2]), .centroid0_d3(bCen0[3]),
    .centroid1_d0(bCen1[0]), .centroid1_d1(bCen1[1]),
    .centroid1_d2(bCen1[2]), .centroid1_d3(bCen1[3]),
    .centroid_valid(bCv), .overflow(bOvf)
  );

  function automatic logic [3:0][15:0] v4(input int a, input int b, input int c, input int e);
    return {16'(e), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drives one cycle of inputs on instance A; returns 1ns after the edge.
  task automatic applyStimulus(input logic sel, input logic [3:0][15:0] d, input logic valid, input logic done);
    aSel   = sel;
    aData  = d;
    aValid = valid;
    aDone  = done;
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after the epoch_done acceptance edge.  Optionally floods the
  // inputs with junk samples and epoch_done while the DUT is dividing.
  task automatic waitForPublish(input string name, input bit junk);
    int  cycles = 0;
    bit  readyBad = 0;
    aValid = junk;
    aDone  = junk;
    aSel   = 1'b0;
    aData  = '0;
    for (int n = 1; n <= LATENCY + 100; n++) begin
      if (junk) begin
        aSel  = 1'($urandom_range(0, 1));
        aData = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      end
      @(posedge clk);
      #1;
      if (aCv) begin
        cycles = n;
        break;
      end
      if (aReady) readyBad = 1;
    end
    aValid = 1'b0;
    aDone  = 1'b0;
    checkOutput({name, " latency"}, 64'(cycles), 64'(LATENCY));
    checkOutput({name, " in_ready low while busy"}, 64'(readyBad), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " valid one cycle"}, 64'(aCv), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " in_ready back"}, 64'(aReady), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{sel:1'b0, d:v4(1,2,3,4),      endMode:2'd0, exp0:'0,               exp1:'0};
    tbl[1] = '{sel:1'b0, d:v4(2,2,2,2),      endMode:2'd1, exp0:v4(1,2,2,3),      exp1:'0};
    tbl[2] = '{sel:1'b0, d:v4(10,20,30,40),  endMode:2'd0, exp0:'0,               exp1:'0};
    tbl[3] = '{sel:1'b0, d:v4(20,40,60,80),  endMode:2'd0, exp0:'0,               exp1:'0};
    tbl[4] = '{sel:1'b1, d:v4(4,4,4,4),      endMode:2'd2, exp0:v4(15,30,45,60),  exp1:v4(4,4,4,4)};
    tbl[5] = '{sel:1'b1, d:v4(7,7,7,7),      endMode:2'd2, exp0:v4(15,30,45,60),  exp1:v4(7,7,7,7)};
    tbl[6] = '{sel:1'b0, d:v4(3,5,9,11),     endMode:2'd0, exp0:'0,               exp1:'0};
    tbl[7] = '{sel:1'b0, d:v4(4,6,10,12),    endMode:2'd2, exp0:v4(3,5,9,11),     exp1:v4(7,7,7,7)};

    rst_n = 1'b0;
    aSel = 0; aData = '0; aValid = 0; aDone = 0;
    bSel = 0; bData = '0; bValid = 0; bDone = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("reset centroid0", 64'(aCen0), 64'd0);
    checkOutput("reset centroid1", 64'(aCen1), 64'd0);
    checkOutput("reset valid", 64'(aCv), 64'd0);
    checkOutput("reset overflow", 64'(aOvf), 64'd0);
    checkOutput("reset in_ready", 64'(aReady), 64'd1);
    @(posedge clk);
    #1;

    // Table of known epochs; centroids carry over between rows.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].sel, tbl[i].d, 1'b1, tbl[i].endMode == 2'd1);
      if (tbl[i].endMode == 2'd2) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      if (tbl[i].endMode != 2'd0) begin
        waitForPublish($sformatf("table row %0d", i), i >= 5);
        checkOutput($sformatf("table row %0d centroid0", i), 64'(aCen0), 64'(tbl[i].exp0));
        checkOutput($sformatf("table row %0d centroid1", i), 64'(aCen1), 64'(tbl[i].exp1));
      end
    end

    // Randomized epochs against an averaging model.
    mCen[0] = tbl[7].exp0;
    mCen[1] = tbl[7].exp1;
    for (int e = 0; e < 6; e++) begin
      int  n;
      bit  endWith;
      for (int k = 0; k < 2; k++) begin
        mCnt[k] = 0;
        for (int j = 0; j < 4; j++) mSum[k][j] = 0;
      end
      n = $urandom_range(1, 6);
      endWith = 1'($urandom_range(0, 1));
      for (int s = 0; s < n; s++) begin
        logic             sel;
        logic [3:0][15:0] d;
        sel = 1'($urandom_range(0, 1));
        d   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(sel, d, 1'b1, endWith && (s == n - 1));
        mCnt[sel]++;
        for (int j = 0; j < 4; j++) mSum[sel][j] += longint'(d[j]);
      end
      if (!endWith) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++)
        if (mCnt[k] != 0)
          for (int j = 0; j < 4; j++) mCen[k][j] = 16'(mSum[k][j] / longint'(mCnt[k]));
      waitForPublish($sformatf("random epoch %0d", e), 1'b1);
      checkOutput($sformatf("random epoch %0d centroid0", e), 64'(aCen0), 64'(mCen[0]));
      checkOutput($sformatf("random epoch %0d centroid1", e), 64'(aCen1), 64'(mCen[1]));
    end

    // Reset 100 cycles into a division: everything clears, no publish follows.
    begin
      bit sawValid = 0;
      applyStimulus(1'b0, v4(50,60,70,80), 1'b1, 1'b1);
      aValid = 0; aDone = 0;
      repeat (100) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid-divide reset centroid0", 64'(aCen0), 64'd0);
      checkOutput("mid-divide reset centroid1", 64'(aCen1), 64'd0);
      checkOutput("mid-divide reset valid", 64'(aCv), 64'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post-reset in_ready", 64'(aReady), 64'd1);
      for (int n = 0; n < LATENCY + 50; n++) begin
        @(posedge clk);
        #1;
        if (aCv) sawValid = 1;
      end
      checkOutput("aborted divide no valid", 64'(sawValid), 64'd0);
      checkOutput("aborted divide centroid0", 64'(aCen0), 64'd0);
    end

    // Narrow counter: fourth sample into a full counter is dropped and flagged.
    begin
      int cycles = 0;
      bSel = 1'b0; bData = v4(8,8,8,8); bValid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("small counter no overflow yet", 64'(bOvf), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("small counter overflow set", 64'(bOvf), 64'd1);
      bValid = 1'b0; bDone = 1'b1;
      @(posedge clk);
      #1;
      bDone = 1'b0;
      for (int n = 1; n <= LATENCY_SML + 50; n++) begin
        @(posedge clk);
        #1;
        if (bCv) begin
          cycles = n;
          break;
        end
      end
      checkOutput("small counter latency", 64'(cycles), 64'(LATENCY_SML));
      checkOutput("small counter centroid0", 64'(bCen0), 64'(v4(8,8,8,8)));
      checkOutput("small counter centroid1", 64'(bCen1), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("small counter overflow cleared", 64'(bOvf), 64'd0);
      checkOutput("small counter in_ready", 64'(bReady), 64'd1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
